// File: rtl/hls_run_sequencer_if.sv
// Bus between the run sequencer, its host register bank, the accelerator and the result consumer.
// Stats outputs exist only when HLS_RUN_SEQUENCER_STATS_EN is defined.
interface hls_run_sequencer_if #(
   parameter int CNT_W  = 32,
   parameter int RUNS_W = 16
);
   logic              go;
   logic [RUNS_W-1:0] num_runs;
   logic [CNT_W-1:0]  timeout_cycles;
   logic              abort;
   logic              dut_reset;
   logic              dut_start_port;
   logic              dut_done_port;
   logic              busy;
   logic              campaign_done;
   logic              res_valid;
   logic              res_ready;
   logic [1:0]        res_status;
   logic [CNT_W-1:0]  res_cycles;
   logic [RUNS_W-1:0] res_index;
`ifdef HLS_RUN_SEQUENCER_STATS_EN
   logic [CNT_W-1:0]        stat_min_cycles;
   logic [CNT_W-1:0]        stat_max_cycles;
   logic [CNT_W+RUNS_W-1:0] stat_sum_cycles;
`endif

   modport slave (
      input  go, num_runs, timeout_cycles, abort, dut_done_port, res_ready,
      output dut_reset, dut_start_port, busy, campaign_done,
      output res_valid, res_status, res_cycles, res_index
`ifdef HLS_RUN_SEQUENCER_STATS_EN
      , output stat_min_cycles, stat_max_cycles, stat_sum_cycles
`endif
   );

   modport master (
      output go, num_runs, timeout_cycles, abort, dut_done_port, res_ready,
      input  dut_reset, dut_start_port, busy, campaign_done,
      input  res_valid, res_status, res_cycles, res_index
`ifdef HLS_RUN_SEQUENCER_STATS_EN
      , input stat_min_cycles, stat_max_cycles, stat_sum_cycles
`endif
   );
endinterface

// File: rtl/hls_run_sequencer.sv
// Back-to-back run controller for an HLS accelerator: reset, start, time, record into a result FIFO.
// Optional min/max/sum cycle statistics enabled by defining HLS_RUN_SEQUENCER_STATS_EN.
//
// state    | meaning
// ---------+----------------------------------------------------------
// S_IDLE   | waiting for go, DUT reset released
// S_DRST   | DUT reset held low for RST_CYCLES cycles
// S_START  | single-cycle start pulse, cycle counter loaded with 1
// S_WAIT   | counting cycles until done, abort or watchdog expiry
// S_RECORD | pushing {status, cycles, index}; stalls while FIFO full
// S_FINISH | campaign_done pulse, busy drops on the following cycle
module hls_run_sequencer #(
   parameter int CNT_W      = 32,
   parameter int RUNS_W     = 16,
   parameter int FIFO_DEPTH = 4,
   parameter int RST_CYCLES = 2
) (
   input logic                  clock,
   input logic                  reset,
   hls_run_sequencer_if.slave   bus
);
   localparam int AW    = $clog2(FIFO_DEPTH);
   localparam int REC_W = 2 + CNT_W + RUNS_W;
   localparam int RCW   = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
   localparam logic [RCW-1:0] RST_INIT = RCW'(RST_CYCLES - 1);

   localparam logic [1:0] ST_DONE    = 2'b01;
   localparam logic [1:0] ST_TIMEOUT = 2'b10;
   localparam logic [1:0] ST_ABORT   = 2'b11;

   typedef enum logic [2:0] {
      S_IDLE, S_DRST, S_START, S_WAIT, S_RECORD, S_FINISH
   } state_t;

   state_t            state_q;
   logic              dut_reset_q;
   logic              start_q;
   logic              busy_q;
   logic              campaign_done_q;
   logic [RUNS_W-1:0] runs_q;
   logic [RUNS_W-1:0] idx_q;
   logic [CNT_W-1:0]  tmo_q;
   logic [CNT_W-1:0]  cnt_q;
   logic [RCW-1:0]    rst_cnt_q;
   logic [1:0]        status_q;

   logic [REC_W-1:0]  mem_q [FIFO_DEPTH];
   logic [AW-1:0]     wptr_q;
   logic [AW-1:0]     rptr_q;
   logic [AW:0]       count_q;
   logic              full;
   logic              empty;
   logic              push;
   logic              pop;

`ifdef HLS_RUN_SEQUENCER_STATS_EN
   localparam int SUM_W = CNT_W + RUNS_W;
   logic [CNT_W-1:0] min_q;
   logic [CNT_W-1:0] max_q;
   logic [SUM_W-1:0] sum_q;
`endif

   assign full  = (count_q == (AW+1)'(FIFO_DEPTH));
   assign empty = (count_q == '0);
   assign pop   = !empty && bus.res_ready;
   // A pop frees the slot in the same cycle, so a full FIFO being drained still accepts the push.
   assign push  = (state_q == S_RECORD) && (!full || pop);

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q         <= S_IDLE;
         dut_reset_q     <= 1'b0;
         start_q         <= 1'b0;
         busy_q          <= 1'b0;
         campaign_done_q <= 1'b0;
         runs_q          <= '0;
         idx_q           <= '0;
         tmo_q           <= '0;
         cnt_q           <= '0;
         rst_cnt_q       <= '0;
         status_q        <= '0;
`ifdef HLS_RUN_SEQUENCER_STATS_EN
         min_q           <= '0;
         max_q           <= '0;
         sum_q           <= '0;
`endif
      end else begin
         start_q         <= 1'b0;
         campaign_done_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               dut_reset_q <= 1'b1;
               if (bus.go) begin
                  runs_q <= bus.num_runs;
                  tmo_q  <= bus.timeout_cycles;
                  busy_q <= 1'b1;
                  idx_q  <= '0;
                  cnt_q  <= '0;
`ifdef HLS_RUN_SEQUENCER_STATS_EN
                  min_q  <= '1;
                  max_q  <= '0;
                  sum_q  <= '0;
`endif
                  if (bus.num_runs == '0) begin
                     state_q         <= S_FINISH;
                     campaign_done_q <= 1'b1;
                  end else begin
                     state_q     <= S_DRST;
                     dut_reset_q <= 1'b0;
                     rst_cnt_q   <= RST_INIT;
                  end
               end
            end
            S_DRST: begin
               if (bus.abort) begin
                  status_q    <= ST_ABORT;
                  state_q     <= S_RECORD;
                  dut_reset_q <= 1'b1;
               end else if (rst_cnt_q == '0) begin
                  state_q     <= S_START;
                  dut_reset_q <= 1'b1;
                  start_q     <= 1'b1;
                  cnt_q       <= CNT_W'(1);
               end else begin
                  rst_cnt_q <= rst_cnt_q - RCW'(1);
               end
            end
            S_START: begin
               if (bus.abort) begin
                  status_q <= ST_ABORT;
                  state_q  <= S_RECORD;
               end else begin
                  state_q <= S_WAIT;
               end
            end
            S_WAIT: begin
               if (bus.dut_done_port) begin
                  status_q <= ST_DONE;
                  state_q  <= S_RECORD;
               end else if (bus.abort) begin
                  status_q <= ST_ABORT;
                  state_q  <= S_RECORD;
               end else if ((tmo_q != '0) && (cnt_q == tmo_q)) begin
                  status_q <= ST_TIMEOUT;
                  state_q  <= S_RECORD;
               end else if (cnt_q != '1) begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end
            S_RECORD: begin
               if (push) begin
                  idx_q <= idx_q + RUNS_W'(1);
`ifdef HLS_RUN_SEQUENCER_STATS_EN
                  if (status_q == ST_DONE) begin
                     if (cnt_q < min_q) min_q <= cnt_q;
                     if (cnt_q > max_q) max_q <= cnt_q;
                     sum_q <= sum_q + SUM_W'(cnt_q);
                  end
`endif
                  if ((idx_q == runs_q - RUNS_W'(1)) || (status_q != ST_DONE)) begin
                     state_q         <= S_FINISH;
                     campaign_done_q <= 1'b1;
                  end else begin
                     state_q     <= S_DRST;
                     dut_reset_q <= 1'b0;
                     rst_cnt_q   <= RST_INIT;
                     cnt_q       <= '0;
                  end
               end
            end
            S_FINISH: begin
               busy_q      <= 1'b0;
               dut_reset_q <= 1'b1;
               state_q     <= S_IDLE;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
      end else begin
         if (push) begin
            mem_q[wptr_q] <= {status_q, cnt_q, idx_q};
            wptr_q        <= wptr_q + AW'(1);
         end
         if (pop) rptr_q <= rptr_q + AW'(1);
         case ({push, pop})
            2'b10:   count_q <= count_q + (AW+1)'(1);
            2'b01:   count_q <= count_q - (AW+1)'(1);
            default: count_q <= count_q;
         endcase
      end
   end

   assign bus.dut_reset      = dut_reset_q;
   assign bus.dut_start_port = start_q;
   assign bus.busy           = busy_q;
   assign bus.campaign_done  = campaign_done_q;
   assign bus.res_valid      = !empty;
   assign {bus.res_status, bus.res_cycles, bus.res_index} = mem_q[rptr_q];
`ifdef HLS_RUN_SEQUENCER_STATS_EN
   assign bus.stat_min_cycles = min_q;
   assign bus.stat_max_cycles = max_q;
   assign bus.stat_sum_cycles = sum_q;
`endif
endmodule

// File: tb/tb_hls_run_sequencer.sv
// Directed bench for hls_run_sequencer with a latency-programmable fake accelerator.
// Stats checks are included when HLS_RUN_SEQUENCER_STATS_EN is defined.
module tb_hls_run_sequencer;
   localparam int CNT_W  = 32;
   localparam int RUNS_W = 16;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   hls_run_sequencer_if #(.CNT_W(CNT_W), .RUNS_W(RUNS_W)) bif ();

   hls_run_sequencer #(
      .CNT_W(CNT_W), .RUNS_W(RUNS_W), .FIFO_DEPTH(4), .RST_CYCLES(2)
   ) dut (
      .clock (clk),
      .reset (rst_n),
      .bus   (bif)
   );

   int errors = 0;
   int checks = 0;
   int lats[8];
   int rem = 0;
   int n_starts = 0, n_rst = 0;
   int start_base = 0, rst_base = 0, got_base = 0;
   logic [49:0] got[$];

   // Monitor: sees pre-edge values, exactly what the DUT samples.
   always @(posedge clk) begin
      if (bif.dut_start_port) n_starts++;
      if (rst_n && !bif.dut_reset) n_rst++;
      if (bif.res_valid && bif.res_ready)
         got.push_back({bif.res_status, bif.res_cycles, bif.res_index});
   end

   // Fake accelerator: done is high in the cycle lat cycles after the start pulse; lat 0 = never.
   always @(negedge clk) begin
      if (bif.dut_start_port) begin
         rem = lats[(n_starts - start_base) % 8];
         bif.dut_done_port = 1'b0;
      end else if (rem > 0) begin
         rem = rem - 1;
         bif.dut_done_port = (rem == 0);
      end else begin
         bif.dut_done_port = 1'b0;
      end
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [63:0] rec(input logic [1:0] s, input int c, input int i);
      return 64'({s, 32'(c), 16'(i)});
   endfunction

   function automatic logic [63:0] rec_at(input int i);
      if (got.size() > got_base + i) return 64'(got[got_base + i]);
      return '1;
   endfunction

   task automatic mark();
      start_base = n_starts;
      rst_base   = n_rst;
      got_base   = got.size();
   endtask

   task automatic go_campaign(input int runs, input int to);
      bif.num_runs       = RUNS_W'(runs);
      bif.timeout_cycles = CNT_W'(to);
      bif.go             = 1'b1;
      @(negedge clk);
      bif.go             = 1'b0;
   endtask

   task automatic wait_done(input string tag);
      logic found;
      found = 1'b0;
      for (int k = 0; k < 300; k++) begin
         if (bif.campaign_done) begin
            found = 1'b1;
            break;
         end
         @(negedge clk);
      end
      chk(tag, 64'(found), 64'(1));
   endtask

   task automatic wait_start(input string tag);
      logic found;
      found = 1'b0;
      for (int k = 0; k < 100; k++) begin
         @(negedge clk);
         if (bif.dut_start_port) begin
            found = 1'b1;
            break;
         end
      end
      chk(tag, 64'(found), 64'(1));
   endtask

   initial begin
      bif.go = 1'b0; bif.num_runs = '0; bif.timeout_cycles = '0;
      bif.abort = 1'b0; bif.res_ready = 1'b0;
      for (int i = 0; i < 8; i++) lats[i] = 0;

      // Reset values
      #1;
      chk("rst_dut_reset", 64'(bif.dut_reset), 64'(0));
      chk("rst_start", 64'(bif.dut_start_port), 64'(0));
      chk("rst_busy", 64'(bif.busy), 64'(0));
      chk("rst_cdone", 64'(bif.campaign_done), 64'(0));
      chk("rst_valid", 64'(bif.res_valid), 64'(0));
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("idle_dut_reset", 64'(bif.dut_reset), 64'(1));

      // Single run, latency 7, with a go pulsed while busy
      lats[0] = 7;
      bif.res_ready = 1'b1;
      mark();
      go_campaign(1, 0);
      chk("s1_busy", 64'(bif.busy), 64'(1));
      bif.num_runs = RUNS_W'(5);
      bif.go = 1'b1;
      @(negedge clk);
      bif.go = 1'b0;
      wait_done("s1_done");
      chk("s1_busy_in_finish", 64'(bif.busy), 64'(1));
      @(negedge clk);
      chk("s1_cdone_pulse", 64'(bif.campaign_done), 64'(0));
      chk("s1_busy_drop", 64'(bif.busy), 64'(0));
      chk("s1_starts", 64'(n_starts - start_base), 64'(1));
      chk("s1_rst_cycles", 64'(n_rst - rst_base), 64'(2));
      chk("s1_nrec", 64'(got.size() - got_base), 64'(1));
      chk("s1_rec0", rec_at(0), rec(2'b01, 7, 0));

      // Multi-run 5/9/3
      lats[0] = 5; lats[1] = 9; lats[2] = 3;
      mark();
      go_campaign(3, 0);
      wait_done("m_done");
      @(negedge clk);
      chk("m_starts", 64'(n_starts - start_base), 64'(3));
      chk("m_rst_cycles", 64'(n_rst - rst_base), 64'(6));
      chk("m_nrec", 64'(got.size() - got_base), 64'(3));
      chk("m_rec0", rec_at(0), rec(2'b01, 5, 0));
      chk("m_rec1", rec_at(1), rec(2'b01, 9, 1));
      chk("m_rec2", rec_at(2), rec(2'b01, 3, 2));
`ifdef HLS_RUN_SEQUENCER_STATS_EN
      chk("m_stat_min", 64'(bif.stat_min_cycles), 64'(3));
      chk("m_stat_max", 64'(bif.stat_max_cycles), 64'(9));
      chk("m_stat_sum", 64'(bif.stat_sum_cycles), 64'(17));
`endif

      // Timeout: never done, watchdog 10, four runs requested
      lats[0] = 0;
      mark();
      go_campaign(4, 10);
      wait_done("t_done");
      @(negedge clk);
      chk("t_starts", 64'(n_starts - start_base), 64'(1));
      chk("t_nrec", 64'(got.size() - got_base), 64'(1));
      chk("t_rec0", rec_at(0), rec(2'b10, 10, 0));
`ifdef HLS_RUN_SEQUENCER_STATS_EN
      chk("t_stat_min", 64'(bif.stat_min_cycles), 64'(32'hFFFF_FFFF));
      chk("t_stat_sum", 64'(bif.stat_sum_cycles), 64'(0));
`endif

      // Backpressure: six runs of latency 2 into a 4-deep FIFO
      for (int i = 0; i < 8; i++) lats[i] = 2;
      bif.res_ready = 1'b0;
      mark();
      go_campaign(6, 0);
      repeat (60) @(negedge clk);
      chk("bp_starts_stalled", 64'(n_starts - start_base), 64'(5));
      chk("bp_valid", 64'(bif.res_valid), 64'(1));
      chk("bp_busy", 64'(bif.busy), 64'(1));
      chk("bp_dut_reset", 64'(bif.dut_reset), 64'(1));
      chk("bp_head", rec(bif.res_status, int'(bif.res_cycles), int'(bif.res_index)), rec(2'b01, 2, 0));
      repeat (10) @(negedge clk);
      chk("bp_starts_held", 64'(n_starts - start_base), 64'(5));
      bif.res_ready = 1'b1;
      wait_done("bp_done");
      for (int k = 0; k < 20; k++) begin
         if (!bif.res_valid) break;
         @(negedge clk);
      end
      @(negedge clk);
      chk("bp_starts", 64'(n_starts - start_base), 64'(6));
      chk("bp_nrec", 64'(got.size() - got_base), 64'(6));
      for (int i = 0; i < 6; i++)
         chk($sformatf("bp_rec%0d", i), rec_at(i), rec(2'b01, 2, i));

      // Abort in IDLE has no effect
      bif.abort = 1'b1;
      @(negedge clk);
      bif.abort = 1'b0;
      @(negedge clk);
      chk("ab_idle_busy", 64'(bif.busy), 64'(0));
      chk("ab_idle_valid", 64'(bif.res_valid), 64'(0));

      // Abort during second run's WAIT at count 4
      lats[0] = 2; lats[1] = 20; lats[2] = 20;
      mark();
      go_campaign(3, 0);
      wait_start("ab_start1");
      wait_start("ab_start2");
      repeat (4) @(negedge clk);
      bif.abort = 1'b1;
      @(negedge clk);
      bif.abort = 1'b0;
      wait_done("ab_done");
      @(negedge clk);
      chk("ab_starts", 64'(n_starts - start_base), 64'(2));
      chk("ab_nrec", 64'(got.size() - got_base), 64'(2));
      chk("ab_rec0", rec_at(0), rec(2'b01, 2, 0));
      chk("ab_rec1", rec_at(1), rec(2'b11, 4, 1));

      // Zero runs
      mark();
      go_campaign(0, 0);
      wait_done("z_done");
      @(negedge clk);
      chk("z_busy", 64'(bif.busy), 64'(0));
      chk("z_starts", 64'(n_starts - start_base), 64'(0));
      chk("z_rst_cycles", 64'(n_rst - rst_base), 64'(0));
      chk("z_nrec", 64'(got.size() - got_base), 64'(0));

      // Async reset mid-run with two records queued
      bif.res_ready = 1'b0;
      lats[0] = 3; lats[1] = 3; lats[2] = 30;
      mark();
      go_campaign(3, 0);
      wait_start("ar_start1");
      wait_start("ar_start2");
      wait_start("ar_start3");
      repeat (2) @(negedge clk);
      chk("ar_valid_before", 64'(bif.res_valid), 64'(1));
      #2 rst_n = 1'b0;
      #1;
      chk("ar_valid", 64'(bif.res_valid), 64'(0));
      chk("ar_busy", 64'(bif.busy), 64'(0));
      chk("ar_dut_reset", 64'(bif.dut_reset), 64'(0));
      chk("ar_start", 64'(bif.dut_start_port), 64'(0));
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      bif.res_ready = 1'b1;
      lats[0] = 4;
      mark();
      go_campaign(1, 0);
      wait_done("ar2_done");
      @(negedge clk);
      chk("ar2_starts", 64'(n_starts - start_base), 64'(1));
      chk("ar2_nrec", 64'(got.size() - got_base), 64'(1));
      chk("ar2_rec0", rec_at(0), rec(2'b01, 4, 0));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
